// File: rtl/ac_nch_slice.sv
// Multi-channel shift-accumulator for bit-sliced partial products.
// Each channel sums weight slices LSB-first and emits a registered result on the final slice.
module ac_nch_slice #(
    parameter int M   = 16,
    parameter int Pa  = 8,
    parameter int Pw  = 4,
    parameter int NS  = 2,
    parameter int NCH = 4,
    localparam int IW  = $clog2(M) + Pa + 1,
    localparam int RW  = IW + Pw * (NS - 1) + 1,
    localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1,
    localparam int SCW = (NS > 1) ? $clog2(NS) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               valid,
    input  logic               last,
    input  logic               cl_en,
    input  logic [CW-1:0]      sel,
    input  logic [IW-1:0]      in_ac,
    output logic [NCH*RW-1:0]  out_acc,
    output logic [NCH-1:0]     busy,
    output logic               out_valid,
    output logic [CW-1:0]      out_ch,
    output logic [RW-1:0]      out_data
);

    logic [RW-1:0]  r_acc [NCH];
    logic [SCW-1:0] r_cnt [NCH];

    logic           w_sel_ok;
    logic           w_final;
    logic [SCW-1:0] w_cnt;
    logic [RW-1:0]  w_sext;
    logic [RW-1:0]  w_term;
    logic [RW-1:0]  w_sum;

    assign w_sel_ok = (int'(sel) < NCH);
    assign w_cnt    = r_cnt[sel];
    assign w_sext   = RW'($signed(in_ac));
    // Exact slice weighting: the guard bit in RW absorbs the shifted sign
    assign w_term   = w_sext << (Pw * int'(w_cnt));
    assign w_sum    = r_acc[sel] + w_term;
    assign w_final  = last || (w_cnt == SCW'(NS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NCH; c++) begin
                r_acc[c] <= '0;
                r_cnt[c] <= '0;
            end
            out_valid <= 1'b0;
            out_ch    <= '0;
            out_data  <= '0;
        end else begin
            out_valid <= 1'b0;
            if (w_sel_ok) begin
                if (cl_en) begin
                    r_acc[sel] <= '0;
                    r_cnt[sel] <= '0;
                end else if (valid && w_final) begin
                    out_data   <= w_sum;
                    out_ch     <= sel;
                    out_valid  <= 1'b1;
                    r_acc[sel] <= '0;
                    r_cnt[sel] <= '0;
                end else if (valid) begin
                    r_acc[sel] <= w_sum;
                    r_cnt[sel] <= w_cnt + SCW'(1);
                end
            end
        end
    end

    always_comb begin
        out_acc = '0;
        busy    = '0;
        for (int c = 0; c < NCH; c++) begin
            out_acc[c*RW +: RW] = r_acc[c];
            busy[c]             = (r_cnt[c] != '0);
        end
    end

endmodule

// File: tb/tb_ac_nch_slice.sv
// Directed bench for ac_nch_slice: accumulate, signed, interleave, clear and async-reset cases.
module tb_ac_nch_slice;

    localparam int IW  = 13;
    localparam int RW  = 18;
    localparam int NCH = 4;
    localparam int CW  = 2;

    logic               clk;
    logic               rst_n;
    logic               valid;
    logic               last;
    logic               cl_en;
    logic [CW-1:0]      sel;
    logic [IW-1:0]      in_ac;
    logic [NCH*RW-1:0]  out_acc;
    logic [NCH-1:0]     busy;
    logic               out_valid;
    logic [CW-1:0]      out_ch;
    logic [RW-1:0]      out_data;

    int n_cmp;
    int n_bad;

    ac_nch_slice dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .valid    (valid),
        .last     (last),
        .cl_en    (cl_en),
        .sel      (sel),
        .in_ac    (in_ac),
        .out_acc  (out_acc),
        .busy     (busy),
        .out_valid(out_valid),
        .out_ch   (out_ch),
        .out_data (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [RW-1:0] acc_of(input int c);
        return out_acc[c*RW +: RW];
    endfunction

    // Apply one cycle of inputs, then sample 1 time unit after the edge.
    task automatic drive(input logic v, input logic l, input logic c,
                         input logic [CW-1:0] s, input logic [IW-1:0] d);
        valid = v; last = l; cl_en = c; sel = s; in_ac = d;
        @(posedge clk);
        #1;
        valid = 1'b0; last = 1'b0; cl_en = 1'b0; in_ac = '0;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        valid = 1'b0; last = 1'b0; cl_en = 1'b0; sel = '0; in_ac = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_acc",   out_acc,   '0);
        chk("rst_busy",  busy,      4'b0000);
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_data",  out_data,  '0);
        chk("rst_ch",    out_ch,    '0);
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 2'd0, '0);
        chk("idle_acc",   out_acc,   '0);
        chk("idle_valid", out_valid, 1'b0);

        // two-slice accumulate on ch0: 5 + 3*16 = 53
        drive(1'b1, 1'b0, 1'b0, 2'd0, 13'd5);
        chk("ch0_busy1",  busy,      4'b0001);
        chk("ch0_acc1",   acc_of(0), 18'd5);
        chk("ch0_nvalid", out_valid, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 2'd0, 13'd3);
        chk("ch0_valid",  out_valid, 1'b1);
        chk("ch0_ch",     out_ch,    2'd0);
        chk("ch0_data",   out_data,  18'd53);
        chk("ch0_acc0",   acc_of(0), 18'd0);
        chk("ch0_busy0",  busy,      4'b0000);
        drive(1'b0, 1'b0, 1'b0, 2'd0, '0);
        chk("hold_valid", out_valid, 1'b0);
        chk("hold_data",  out_data,  18'd53);
        chk("hold_ch",    out_ch,    2'd0);

        // signed on ch2: -7 + (-2)*16 = -39
        drive(1'b1, 1'b0, 1'b0, 2'd2, 13'h1FF9);
        chk("sgn_acc1",  acc_of(2), 18'h3FFF9);
        chk("sgn_busy",  busy,      4'b0100);
        drive(1'b1, 1'b0, 1'b0, 2'd2, 13'h1FFE);
        chk("sgn_valid", out_valid, 1'b1);
        chk("sgn_ch",    out_ch,    2'd2);
        chk("sgn_data",  out_data,  18'h3FFD9);
        chk("sgn_acc0",  acc_of(2), 18'd0);

        // interleave ch1 / ch3, back-to-back results
        drive(1'b1, 1'b0, 1'b0, 2'd1, 13'd4);
        chk("il_acc1",   acc_of(1), 18'd4);
        chk("il_busy",   busy,      4'b0010);
        chk("il_nvalid", out_valid, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 2'd3, 13'd1);
        chk("il_v3",     out_valid, 1'b1);
        chk("il_ch3",    out_ch,    2'd3);
        chk("il_d3",     out_data,  18'd1);
        chk("il_hold1",  acc_of(1), 18'd4);
        chk("il_busy3",  busy,      4'b0010);
        drive(1'b1, 1'b0, 1'b0, 2'd1, 13'd2);
        chk("il_v1",     out_valid, 1'b1);
        chk("il_ch1",    out_ch,    2'd1);
        chk("il_d1",     out_data,  18'd36);
        chk("il_busy0",  busy,      4'b0000);

        // clear wins over simultaneous valid
        drive(1'b1, 1'b0, 1'b0, 2'd0, 13'd9);
        chk("clr_acc9",  acc_of(0), 18'd9);
        drive(1'b1, 1'b0, 1'b1, 2'd0, 13'd6);
        chk("clr_acc",   acc_of(0), 18'd0);
        chk("clr_busy",  busy,      4'b0000);
        chk("clr_nval",  out_valid, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 2'd0, 13'd2);
        chk("clr_acc2",  acc_of(0), 18'd2);
        chk("clr_busy1", busy,      4'b0001);
        drive(1'b1, 1'b0, 1'b0, 2'd0, 13'd1);
        chk("clr_valid", out_valid, 1'b1);
        chk("clr_data",  out_data,  18'd18);

        // async reset between edges
        drive(1'b1, 1'b0, 1'b0, 2'd1, 13'd4);
        chk("ar_pre_acc",  acc_of(1), 18'd4);
        chk("ar_pre_busy", busy,      4'b0010);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_acc",   acc_of(1), 18'd0);
        chk("ar_busy",  busy,      4'b0000);
        chk("ar_data",  out_data,  18'd0);
        chk("ar_valid", out_valid, 1'b0);
        rst_n = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 2'd1, 13'd3);
        chk("ar_v",     out_valid, 1'b1);
        chk("ar_ch",    out_ch,    2'd1);
        chk("ar_d",     out_data,  18'd3);
        chk("ar_busy2", busy,      4'b0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
